cam_param: RTL and testbench
============================

Name: cam_param

Overview:
- Parametrised successor to the team's fixed 16x8 CAM.
- Generalised in data width and depth.
- Adds per-entry valid bits, entry erase, ternary (masked) search, a multi-hit flag, an occupancy counter and a free-slot finder.
- Used as the lookup store for tag/ID matching; search has a registered result one cycle after the request.

Parameters:
- DATA_W, 8, width of stored word and search key
- DEPTH, 16, number of entries (≥2)
- ADDR_W, $clog2(DEPTH), entry index width

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- enable  input  1  search request, sampled on rising edge
- write  input  1  write data into entry addr, sets its valid bit
- erase  input  1  clear valid bit of entry addr
- addr  input  ADDR_W  entry index for write/erase
- data  input  DATA_W  write data, or search key when enable
- mask  input  DATA_W  search care mask; 1 = compare bit, 0 = don't care
- out  output  ADDR_W  registered index of lowest matching valid entry
- found  output  1  registered: at least one valid entry matched
- multi  output  1  registered: two or more valid entries matched
- count  output  ADDR_W+1  number of valid entries
- free_addr  output  ADDR_W  lowest-index invalid entry (combinational from state)
- full  output  1  all DEPTH entries valid (combinational from state)

Behaviour:
- Reset (rst_n=0 at rising edge):
  - All valid bits cleared; stored data is don't-care.
  - out=0, found=0, multi=0, count=0.
  - Hence free_addr=0, full=0.
  - Reset overrides every operation in the same cycle.
- Write (write=1):
  - mem[addr]<=data, valid[addr]<=1.
  - count+1 only if entry was previously invalid; overwriting a valid entry leaves count unchanged.
- Erase (erase=1, write=0):
  - valid[addr]<=0.
  - count-1 only if entry was previously valid; erasing an invalid entry is a no-op.
- write=1 and erase=1 together: write wins, erase ignored.
- addr ≥ DEPTH (non-power-of-2 DEPTH): write/erase ignored, count unchanged.
- Search (enable=1):
  - Entry i matches iff valid[i] and ((mem[i] ^ data) & mask)==0.
  - Comparison uses contents before this edge: a same-cycle write/erase is not visible to the search.
  - Write and search in the same cycle therefore use the same data bus.
  - Results registered at this edge, visible the following cycle (latency 1):
    - found = any match.
    - out = lowest matching index (priority to index 0).
    - multi = match count ≥2.
  - No match: found=0, multi=0, out=0.
  - mask all zeros: matches every valid entry; empty CAM gives found=0.
- enable=0: out/found/multi hold their last values.
- free_addr:
  - Lowest index with valid=0.
  - When full=1, free_addr=0 and must not be used.
  - Reflects state after the most recent edge.
- count saturation: count never exceeds DEPTH and never underflows below 0; both hold by construction and are checked by assertion.
- No internal FSM beyond valid/count registers. Each cycle performs at most one modify op (write or erase) plus at most one search.

Test Plan:
- Reset then fill: DEPTH=16, write addr i data 0x10+i for i=0..15 → count=16, full=1; search 0x13, mask 0xFF → next cycle found=1, out=3, multi=0.
- Miss: search 0x55, 0x00, 0xFF with mask 0xFF on filled CAM → found=0, out=0, multi=0; count stays 16.
- Duplicates: write 0xAA to addr 0, 5, 10 (count stays 16); search 0xAA → found=1, out=0, multi=1; erase addr 0, search 0xAA → out=5, multi=1, count=15, free_addr=0, full=0.
- Ternary: fresh CAM, write 0x10..0x1F to 0..15; search data 0x00 mask 0xF0 → found=0; search data 0x1F mask 0xF0 → found=1, out=0, multi=1; mask 0x00 → out=0, multi=1.
- Same-cycle ops: entry 7 holds 0x17; in one cycle write addr 7 data 0x99 with enable=1 → result found=0 (old content 0x17 mismatches key 0x99); next cycle search 0x99 → found=1, out=7. write+erase same addr → entry valid, count unchanged if already valid.
- Reset mid-operation: after duplicate test assert rst_n=0 together with write=1 and enable=1 → next cycle found=0, count=0, free_addr=0; subsequent search 0xAA → found=0.

Source files
------------

// File: rtl/cam_param.sv
// Parametrised content-addressable memory with per-entry valid bits, ternary
// search, multi-hit detection, occupancy counter and free-slot finder.
module cam_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              write,
  input  logic              erase,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] mask,
  output logic [ADDR_W-1:0] out,
  output logic              found,
  output logic              multi,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] free_addr,
  output logic              full
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] out_q, out_d;
  logic              found_q, found_d;
  logic              multi_q, multi_d;

  logic [DEPTH-1:0]  match_s;
  logic [ADDR_W-1:0] hit_idx_s;
  logic              hit_any_s;
  logic              hit_multi_s;
  logic [ADDR_W-1:0] free_idx_s;
  logic              addr_ok_s;

  // Ternary compare of the key against every valid entry (pre-edge contents).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i] = valid_q[i] && (((mem_q[i] ^ data) & mask) == {DATA_W{1'b0}});
    end
  end

  // Descending scan so the last assignment is the lowest index; a second hit sets multi.
  always_comb begin
    hit_idx_s   = {ADDR_W{1'b0}};
    hit_any_s   = 1'b0;
    hit_multi_s = 1'b0;
    free_idx_s  = {ADDR_W{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_s[i]) begin
        hit_multi_s = hit_multi_s | hit_any_s;
        hit_any_s   = 1'b1;
        hit_idx_s   = ADDR_W'(i);
      end else begin
        hit_multi_s = hit_multi_s;
      end
      if (!valid_q[i]) begin
        free_idx_s = ADDR_W'(i);
      end else begin
        free_idx_s = free_idx_s;
      end
    end
  end

  // Next-state for storage, valid bits and occupancy; write has priority over erase.
  always_comb begin
    addr_ok_s = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
    mem_d     = mem_q;
    valid_d   = valid_q;
    count_d   = count_q;
    if (write && addr_ok_s) begin
      mem_d[addr]   = data;
      valid_d[addr] = 1'b1;
      if (!valid_q[addr]) begin
        count_d = count_q + (ADDR_W + 1)'(1);
      end else begin
        count_d = count_q;
      end
    end else if (erase && addr_ok_s) begin
      valid_d[addr] = 1'b0;
      if (valid_q[addr]) begin
        count_d = count_q - (ADDR_W + 1)'(1);
      end else begin
        count_d = count_q;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Search results update only on a request and otherwise hold.
  always_comb begin
    out_d   = out_q;
    found_d = found_q;
    multi_d = multi_q;
    if (enable) begin
      out_d   = hit_idx_s;
      found_d = hit_any_s;
      multi_d = hit_multi_s;
    end else begin
      out_d   = out_q;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= {DEPTH{1'b0}};
      count_q <= {(ADDR_W + 1){1'b0}};
      out_q   <= {ADDR_W{1'b0}};
      found_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      out_q   <= out_d;
      found_q <= found_d;
      multi_q <= multi_d;
    end
  end

  // Stored words need no reset; their valid bits gate every use.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out       = out_q;
  assign found     = found_q;
  assign multi     = multi_q;
  assign count     = count_q;
  assign full      = &valid_q;
  assign free_addr = full ? {ADDR_W{1'b0}} : free_idx_s;

  cam_param_chk #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .count (count_q),
    .full  (full)
  );

endmodule

// Occupancy invariants: never above DEPTH, and full agrees with the counter.
module cam_param_chk #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic            clk,
  input logic            rst_n,
  input logic [ADDR_W:0] count,
  input logic            full
);

  a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
    count <= (ADDR_W + 1)'(DEPTH));

  a_full_count: assert property (@(posedge clk) disable iff (!rst_n)
    full == (count == (ADDR_W + 1)'(DEPTH)));

endmodule

// File: tb/tb_cam_param.sv
// Self-checking bench for cam_param: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_cam_param;
  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0, write = 1'b0, erase = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data = '0, mask = '0;
  logic [AW-1:0] out;
  logic          found, multi, full;
  logic [AW:0]   count;
  logic [AW-1:0] free_addr;

  int total = 0;
  int bad   = 0;

  // reference model
  bit            m_valid [DP];
  logic [DW-1:0] m_mem   [DP];
  logic [AW-1:0] e_out;
  logic          e_found, e_multi;

  cam_param #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .write(write), .erase(erase),
    .addr(addr), .data(data), .mask(mask), .out(out), .found(found),
    .multi(multi), .count(count), .free_addr(free_addr), .full(full)
  );

  always #5 clk = ~clk;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DP; i++) n += m_valid[i] ? 1 : 0;
    return n;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < DP; i++) if (!m_valid[i]) return i;
    return 0;
  endfunction

  task automatic cycle(input bit wr, input bit er, input bit en,
                       input int a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    int hits;
    int first;
    @(negedge clk);
    write = wr; erase = er; enable = en; addr = AW'(a); data = d; mask = m;
    if (en) begin
      hits = 0; first = 0;
      for (int i = 0; i < DP; i++) begin
        if (m_valid[i] && (((m_mem[i] ^ d) & m) == 8'h00)) begin
          if (hits == 0) first = i;
          hits++;
        end
      end
      e_found = (hits > 0);
      e_multi = (hits >= 2);
      e_out   = AW'(first);
    end
    if (wr) begin
      m_mem[a] = d; m_valid[a] = 1'b1;
    end else if (er) begin
      m_valid[a] = 1'b0;
    end
    @(posedge clk); #1;
    write = 1'b0; erase = 1'b0; enable = 1'b0;
  endtask

  task automatic do_reset(input bit wr, input bit en, input int a, input logic [DW-1:0] d);
    @(negedge clk);
    rst_n = 1'b0; write = wr; enable = en; addr = AW'(a); data = d; mask = 8'hFF;
    for (int i = 0; i < DP; i++) m_valid[i] = 1'b0;
    e_found = 1'b0; e_multi = 1'b0; e_out = '0;
    @(posedge clk); #1;
    rst_n = 1'b1; write = 1'b0; enable = 1'b0;
  endtask

  task automatic fill();
    for (int i = 0; i < DP; i++) cycle(1'b1, 1'b0, 1'b0, i, 8'(8'h10 + i), 8'h00);
  endtask

  task automatic test_reset();
    do_reset(1'b0, 1'b0, 0, 8'h00);
    total++;
    if ({out, found, multi, count, free_addr, full} !== {4'd0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset: out=%0d found=%0b multi=%0b count=%0d free=%0d full=%0b, want all zero",
               out, found, multi, count, free_addr, full);
    end
  endtask

  task automatic test_fill();
    fill();
    total++;
    if (count !== 5'd16 || full !== 1'b1) begin
      bad++; $display("FAIL fill_count: count=%0d full=%0b, want 16 1", count, full);
    end
    cycle(1'b0, 1'b0, 1'b1, 0, 8'h13, 8'hFF);
    total++;
    if ({found, out, multi} !== {1'b1, 4'd3, 1'b0}) begin
      bad++; $display("FAIL fill_search: found=%0b out=%0d multi=%0b, want 1 3 0", found, out, multi);
    end
  endtask

  task automatic test_miss();
    logic [DW-1:0] keys [3];
    keys[0] = 8'h55; keys[1] = 8'h00; keys[2] = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 0, keys[k], 8'hFF);
      total++;
      if ({found, out, multi, count} !== {1'b0, 4'd0, 1'b0, 5'd16}) begin
        bad++; $display("FAIL miss_%02h: found=%0b out=%0d multi=%0b count=%0d, want 0 0 0 16",
                        keys[k], found, out, multi, count);
      end
    end
  endtask

  task automatic test_duplicates();
    cycle(1'b1, 1'b0, 1'b0, 0, 8'hAA, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 5, 8'hAA, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 10, 8'hAA, 8'h00);
    total++;
    if (count !== 5'd16) begin
      bad++; $display("FAIL dup_overwrite_count: count=%0d, want 16", count);
    end
    cycle(1'b0, 1'b0, 1'b1, 0, 8'hAA, 8'hFF);
    total++;
    if ({found, out, multi} !== {1'b1, 4'd0, 1'b1}) begin
      bad++; $display("FAIL dup_search: found=%0b out=%0d multi=%0b, want 1 0 1", found, out, multi);
    end
    cycle(1'b0, 1'b1, 1'b0, 0, 8'h00, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 0, 8'hAA, 8'hFF);
    total++;
    if ({found, out, multi, count, free_addr, full} !== {1'b1, 4'd5, 1'b1, 5'd15, 4'd0, 1'b0}) begin
      bad++; $display("FAIL dup_erase: found=%0b out=%0d multi=%0b count=%0d free=%0d full=%0b, want 1 5 1 15 0 0",
                      found, out, multi, count, free_addr, full);
    end
    cycle(1'b0, 1'b1, 1'b0, 0, 8'h00, 8'h00);
    total++;
    if (count !== 5'd15) begin
      bad++; $display("FAIL erase_invalid_noop: count=%0d, want 15", count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1, 1'b1, 3, 8'hAA);
    total++;
    if ({found, count, free_addr} !== {1'b0, 5'd0, 4'd0}) begin
      bad++; $display("FAIL reset_mid: found=%0b count=%0d free=%0d, want 0 0 0", found, count, free_addr);
    end
    cycle(1'b0, 1'b0, 1'b1, 0, 8'hAA, 8'hFF);
    total++;
    if (found !== 1'b0) begin
      bad++; $display("FAIL reset_mid_search: found=%0b, want 0", found);
    end
  endtask

  task automatic test_ternary();
    do_reset(1'b0, 1'b0, 0, 8'h00);
    fill();
    cycle(1'b0, 1'b0, 1'b1, 0, 8'h00, 8'hF0);
    total++;
    if (found !== 1'b0) begin
      bad++; $display("FAIL tern_00_F0: found=%0b, want 0", found);
    end
    cycle(1'b0, 1'b0, 1'b1, 0, 8'h1F, 8'hF0);
    total++;
    if ({found, out, multi} !== {1'b1, 4'd0, 1'b1}) begin
      bad++; $display("FAIL tern_1F_F0: found=%0b out=%0d multi=%0b, want 1 0 1", found, out, multi);
    end
    cycle(1'b0, 1'b0, 1'b1, 0, 8'h5A, 8'h00);
    total++;
    if ({found, out, multi} !== {1'b1, 4'd0, 1'b1}) begin
      bad++; $display("FAIL tern_mask0: found=%0b out=%0d multi=%0b, want 1 0 1", found, out, multi);
    end
    cycle(1'b0, 1'b0, 1'b0, 0, 8'h00, 8'h00);
    total++;
    if ({found, out, multi} !== {1'b1, 4'd0, 1'b1}) begin
      bad++; $display("FAIL hold: found=%0b out=%0d multi=%0b, want 1 0 1", found, out, multi);
    end
  endtask

  task automatic test_same_cycle();
    cycle(1'b1, 1'b0, 1'b1, 7, 8'h99, 8'hFF);
    total++;
    if (found !== 1'b0) begin
      bad++; $display("FAIL same_cycle_old: found=%0b, want 0", found);
    end
    cycle(1'b0, 1'b0, 1'b1, 0, 8'h99, 8'hFF);
    total++;
    if ({found, out} !== {1'b1, 4'd7}) begin
      bad++; $display("FAIL same_cycle_new: found=%0b out=%0d, want 1 7", found, out);
    end
    cycle(1'b1, 1'b1, 1'b0, 7, 8'h77, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 0, 8'h77, 8'hFF);
    total++;
    if ({found, out, count} !== {1'b1, 4'd7, 5'd16}) begin
      bad++; $display("FAIL write_erase: found=%0b out=%0d count=%0d, want 1 7 16", found, out, count);
    end
  endtask

  task automatic test_random();
    int op;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, DP - 1), 8'($urandom));
      end else begin
        op = $urandom_range(0, 4);
        cycle(op == 0 || op == 2 || op == 4, op == 1 || op == 2, 1'($urandom_range(0, 1)),
              $urandom_range(0, DP - 1), 8'($urandom_range(0, 7) | 8'h30),
              ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom | 32'hF0));
      end
      total++;
      if ({out, found, multi, count, free_addr, full} !==
          {e_out, e_found, e_multi, 5'(m_count()), 4'(m_free()), (m_count() == DP)}) begin
        bad++;
        $display("FAIL random[%0d]: out=%0d found=%0b multi=%0b count=%0d free=%0d full=%0b, want %0d %0b %0b %0d %0d %0b",
                 n, out, found, multi, count, free_addr, full,
                 e_out, e_found, e_multi, m_count(), m_free(), (m_count() == DP));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DP; i++) begin
      m_valid[i] = 1'b0; m_mem[i] = '0;
    end
    e_out = '0; e_found = 1'b0; e_multi = 1'b0;
    test_reset();
    test_fill();
    test_miss();
    test_duplicates();
    test_reset_mid();
    test_ternary();
    test_same_cycle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
